truth_table_sweep: RTL and testbench
====================================

TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 Parameter: N_IN, default 3, number of DUT input bits driven (1..8).
REQ-002 Parameter: DWELL, default 10, clock cycles each input vector is held (2..1024).
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  begin a sweep; sampled each cycle.
REQ-006 Port: loop  input  1  continuous mode when high; sampled at end of each sweep.
REQ-007 Port: expected  input  2**N_IN  golden truth table; bit k is the expected y for vector k.
REQ-008 Port: y_in  input  1  combinational DUT response to vec_out.
REQ-009 Port: vec_out  output  N_IN  registered vector driven to the DUT inputs; MSB maps to the DUT's first input (a).
REQ-010 Port: busy  output  1  high while a sweep is in progress.
REQ-011 Port: done  output  1  high when a sweep has completed.
REQ-012 Port: pass  output  1  high when the captured table equals expected; valid while done=1.
REQ-013 Port: table_out  output  2**N_IN  captured truth table.
REQ-014 Port: mismatch_cnt  output  N_IN+1  number of vectors whose captured y differs from expected in the current or last sweep.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 In IDLE, start=1 SHALL move the FSM to RUN on the next edge; on that same edge idx=0, dwell_cnt=0, table_out=0 and mismatch_cnt=0.
REQ-017 vec_out SHALL equal idx at all times: 0 in IDLE and in DONE, and the current vector in RUN.
REQ-018 In RUN, dwell_cnt SHALL increment every cycle; the cycle with dwell_cnt==DWELL-1 is the sample cycle.
REQ-019 On the sample cycle, y_in SHALL be written into table_out[idx]; mismatch_cnt SHALL increment when y_in != expected[idx].
REQ-020 After a sample with idx < 2**N_IN-1, idx SHALL increment and dwell_cnt SHALL return to 0.
- Each vector is held exactly DWELL cycles.
- A full sweep is 2**N_IN*DWELL cycles from entering RUN.
REQ-021 After a sample with idx == 2**N_IN-1 and loop=0, the FSM SHALL go to DONE; pass SHALL be registered as (final table == expected), including the bit just sampled.
REQ-022 After a sample with idx == 2**N_IN-1 and loop=1:
- the FSM SHALL stay in RUN;
- idx SHALL wrap to 0;
- done SHALL pulse high for exactly one cycle, with pass valid in that cycle;
- table_out and mismatch_cnt SHALL hold for that one cycle, then clear at the first sample-free transition into the new sweep.
REQ-023 In DONE, done=1 and pass, table_out and mismatch_cnt SHALL hold until start=1, which restarts exactly as in REQ-016.
REQ-024 start SHALL be ignored while in RUN.
REQ-025 busy SHALL equal (state==RUN).
REQ-026 done and busy SHALL never both be high, except during the one-cycle loop pulse of REQ-022.
REQ-027 dwell_cnt SHALL be clog2(DWELL) bits wide; idx SHALL be N_IN bits wide.
- idx wrap-around relies on natural overflow only in loop mode.
- mismatch_cnt SHALL not overflow, because its maximum value is 2**N_IN.

Reset
REQ-028 reset=1 at any clock edge SHALL force the outputs as follows, overriding start and a sweep in progress:
- state=IDLE, idx=0, dwell_cnt=0;
- vec_out=0, busy=0, done=0, pass=0, table_out=0, mismatch_cnt=0.
REQ-029 A reset in the middle of a sweep SHALL discard any partial table; the first cycle after reset is released SHALL accept start.

Structure
REQ-030 The state enum typedef (IDLE, RUN, DONE) SHALL live in shared package tt_sweep_pkg, together with a constant for the maximum N_IN (8).
REQ-031 The dwell counter SHALL be a sub-module, dwell_timer, parameterised by DWELL, with ports clk, reset, clear, en and a single-cycle output tick (dwell_cnt==DWELL-1).
REQ-032 The DUT SHALL be external; the bench connects vec_out to the DUT inputs and the DUT output to y_in.

Verification (N_IN=3, DWELL=4 unless stated)
REQ-033 Majority DUT, expected=8'b1110_1000, start pulsed in cycle 0 -> expected response:
- vec_out steps 0..7, each value held 4 cycles;
- done rises 33 cycles after the start edge;
- table_out=8'hE8, pass=1, mismatch_cnt=0.
REQ-034 Same DUT, expected=8'b1110_1001 -> expected response: table_out=8'hE8, pass=0, mismatch_cnt=1.
REQ-035 loop=1 for two sweeps, with y_in forced 1 in the second sweep -> expected response:
- done pulses once after cycle 32 with pass=1;
- done pulses again after cycle 64 with table_out=8'hFF and mismatch_cnt=4.
REQ-036 start re-asserted at vector 3 in the middle of a sweep -> expected response: no restart, and sweep timing is unchanged.
REQ-037 reset asserted at vector 5 -> expected response: next cycle vec_out=0, busy=0, table_out=0; a following start performs a full, clean sweep.
REQ-038 N_IN=1, DWELL=2, inverter DUT, expected=2'b01 -> expected response: done rises 5 cycles after start, table_out=2'b01, pass=1.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared types and limits for the truth-table sweep engine.
package tt_sweep_pkg;

  // Sweep controller states; also exported on the interface for debug.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest supported number of driven DUT inputs.
  localparam int MAX_N_IN = 8;

endpackage

// File: rtl/truth_table_sweep_if.sv
// Signal bundle between the sweep engine (slave) and whoever drives it (master).
//
// Handshake: start is a level sampled on every rising edge. It is accepted
// only in IDLE or DONE. busy is high for the whole sweep. done is high in DONE
// and, in loop mode, for one cycle at the end of each sweep. pass, table_out
// and mismatch_cnt are meaningful while done is high.
interface truth_table_sweep_if #(
  parameter int N_IN = 3
);
  logic                   start;
  logic                   loop;
  logic [(1<<N_IN)-1:0]   expected;
  logic                   y_in;
  logic [N_IN-1:0]        vec_out;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [(1<<N_IN)-1:0]   table_out;
  logic [N_IN:0]          mismatch_cnt;
  tt_sweep_pkg::state_t   state;

  modport master (
    output start, loop, expected, y_in,
    input  vec_out, busy, done, pass, table_out, mismatch_cnt, state
  );

  modport slave (
    input  start, loop, expected, y_in,
    output vec_out, busy, done, pass, table_out, mismatch_cnt, state
  );
endinterface

// File: rtl/dwell_timer.sv
// Counts the cycles a vector is held; tick marks the last cycle of the hold.
module dwell_timer #(
  parameter int DWELL = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: clear wins, otherwise count up and wrap after the sample cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/truth_table_sweep.sv
// Steps an external combinational DUT through every input vector, captures
// its response into a truth table and compares it against a golden table.
module truth_table_sweep
  import tt_sweep_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int DWELL = 10
) (
  input  logic                clk,
  input  logic                reset,
  truth_table_sweep_if.slave  bus
);
  localparam int NV = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 1);

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [NV-1:0]     table_q, table_d;
  logic [N_IN:0]     mis_q, mis_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              tick;

  // The hold counter runs only in RUN and is parked at zero otherwise, so a
  // sweep always starts with a full dwell on vector 0.
  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clear (state_q != RUN),
    .en    (state_q == RUN),
    .tick  (tick)
  );

  // Sweep sequencing, capture and scoring.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    table_d = table_q;
    mis_d   = mis_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          idx_d   = '0;
          table_d = '0;
          mis_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        done_d = 1'b0;
        // First cycle after a loop wrap: results were shown for one cycle,
        // start the new sweep clean. DWELL >= 2 keeps this off a sample cycle.
        if (done_q) begin
          table_d = '0;
          mis_d   = '0;
        end
        if (tick) begin
          table_d[idx_q] = bus.y_in;
          if (bus.y_in != bus.expected[idx_q]) mis_d = mis_d + (N_IN+1)'(1);
          if (idx_q == LAST_IDX) begin
            pass_d = (table_d == bus.expected);
            done_d = 1'b1;
            if (bus.loop) begin
              idx_d = idx_q + N_IN'(1);  // wraps to 0
            end else begin
              state_d = DONE;
              idx_d   = '0;
            end
          end else begin
            idx_d = idx_q + N_IN'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      table_q <= '0;
      mis_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      mis_q   <= mis_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.vec_out      = idx_q;
  assign bus.busy         = (state_q == RUN);
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.table_out    = table_q;
  assign bus.mismatch_cnt = mis_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_truth_table_sweep.sv
// Directed bench for truth_table_sweep: majority DUT on a 3-input engine and
// an inverter DUT on a 1-input engine, results checked through a scoreboard.
module tb_truth_table_sweep;
  import tt_sweep_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  logic y_force;

  // Scoreboard entries: {pass, mismatch_cnt[3:0], table_out[7:0]}
  logic [12:0] exp_q[$];

  truth_table_sweep_if #(.N_IN(3)) if_a ();
  truth_table_sweep_if #(.N_IN(1)) if_b ();

  truth_table_sweep #(.N_IN(3), .DWELL(4)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  truth_table_sweep #(.N_IN(1), .DWELL(2)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

  // ---------------- external DUT models ----------------
  function automatic logic maj(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  assign if_a.y_in = y_force ? 1'b1 : maj(if_a.vec_out);
  assign if_b.y_in = ~if_b.vec_out[0];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] golden, input bit force1);
    logic [7:0] tt;
    logic [3:0] mis;
    for (int v = 0; v < 8; v++) tt[v] = force1 ? 1'b1 : maj(3'(v));
    mis = 4'($countones(tt ^ golden));
    exp_q.push_back({(tt == golden), mis, tt});
  endtask

  task automatic pop_check(input string tag);
    logic [12:0] got;
    logic [12:0] exp;
    got = {if_a.pass, if_a.mismatch_cnt, if_a.table_out};
    check({tag, "_sb_avail"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check({tag, "_result"}, 32'(got), 32'(exp));
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; afterwards the engine is on vector 0.
  task automatic begin_sweep(input logic [7:0] golden);
    if_a.expected = golden;
    if_a.start    = 1'b1;
    step();
    if_a.start    = 1'b0;
    check("entry_busy", 32'(if_a.busy), 32'd1);
    check("entry_vec",  32'(if_a.vec_out), 32'd0);
    check("entry_done", 32'(if_a.done), 32'd0);
  endtask

  // Follow one sweep edge by edge; optionally re-pulse start mid-sweep.
  task automatic track_sweep(input int restart_at);
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k < 32) begin
        check("sweep_vec",  32'(if_a.vec_out), 32'(k / 4));
        check("sweep_busy", 32'(if_a.busy), 32'd1);
        check("sweep_done", 32'(if_a.done), 32'd0);
      end
      if (k == 1) begin
        check("sweep_table_clr", 32'(if_a.table_out), 32'd0);
        check("sweep_mis_clr",   32'(if_a.mismatch_cnt), 32'd0);
      end
      if_a.start = (k == restart_at);
    end
    if_a.start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    reset = 1'b1;
    y_force = 1'b0;
    if_a.start = 1'b0; if_a.loop = 1'b0; if_a.expected = '0;
    if_b.start = 1'b0; if_b.loop = 1'b0; if_b.expected = '0;
    step(); step(); step();
    check("rst_vec",   32'(if_a.vec_out), 32'd0);
    check("rst_busy",  32'(if_a.busy), 32'd0);
    check("rst_done",  32'(if_a.done), 32'd0);
    check("rst_pass",  32'(if_a.pass), 32'd0);
    check("rst_table", 32'(if_a.table_out), 32'd0);
    check("rst_mis",   32'(if_a.mismatch_cnt), 32'd0);
    check("rst_state", 32'(if_a.state), 32'(IDLE));
    reset = 1'b0;

    // Majority, correct golden table.
    push_exp(8'hE8, 1'b0);
    begin_sweep(8'hE8);
    track_sweep(0);
    check("maj_done", 32'(if_a.done), 32'd1);
    check("maj_busy", 32'(if_a.busy), 32'd0);
    check("maj_table_const", 32'(if_a.table_out), 32'hE8);
    pop_check("maj");
    step(); step(); step();
    check("hold_done",  32'(if_a.done), 32'd1);
    check("hold_vec",   32'(if_a.vec_out), 32'd0);
    check("hold_table", 32'(if_a.table_out), 32'hE8);
    check("hold_pass",  32'(if_a.pass), 32'd1);
    check("hold_state", 32'(if_a.state), 32'(DONE));

    // Wrong golden table, start re-pulsed at vector 3 (ignored).
    push_exp(8'hE9, 1'b0);
    begin_sweep(8'hE9);
    track_sweep(12);
    check("bad_done", 32'(if_a.done), 32'd1);
    check("bad_mis_const", 32'(if_a.mismatch_cnt), 32'd1);
    pop_check("bad");

    // Loop mode: second sweep sees y_in stuck at 1.
    if_a.loop = 1'b1;
    push_exp(8'hE8, 1'b0);
    begin_sweep(8'hE8);
    track_sweep(0);
    check("loop1_done", 32'(if_a.done), 32'd1);
    check("loop1_busy", 32'(if_a.busy), 32'd1);
    pop_check("loop1");
    y_force = 1'b1;
    push_exp(8'hE8, 1'b1);
    track_sweep(0);
    check("loop2_done", 32'(if_a.done), 32'd1);
    check("loop2_busy", 32'(if_a.busy), 32'd1);
    check("loop2_table_const", 32'(if_a.table_out), 32'hFF);
    check("loop2_mis_const", 32'(if_a.mismatch_cnt), 32'd4);
    pop_check("loop2");
    step();
    check("loop_pulse_end", 32'(if_a.done), 32'd0);
    check("loop_still_run", 32'(if_a.busy), 32'd1);
    if_a.loop = 1'b0;
    y_force = 1'b0;

    // Reset in the middle of a sweep (vector 5), then a clean sweep.
    reset = 1'b1; step(); reset = 1'b0;
    check("rst2_state", 32'(if_a.state), 32'(IDLE));
    begin_sweep(8'hE8);
    for (int k = 1; k <= 20; k++) step();
    check("pre_rst_vec", 32'(if_a.vec_out), 32'd5);
    reset = 1'b1;
    step();
    check("midrst_vec",   32'(if_a.vec_out), 32'd0);
    check("midrst_busy",  32'(if_a.busy), 32'd0);
    check("midrst_table", 32'(if_a.table_out), 32'd0);
    check("midrst_done",  32'(if_a.done), 32'd0);
    check("midrst_mis",   32'(if_a.mismatch_cnt), 32'd0);
    reset = 1'b0;
    push_exp(8'hE8, 1'b0);
    begin_sweep(8'hE8);
    track_sweep(0);
    check("clean_done", 32'(if_a.done), 32'd1);
    pop_check("clean");

    // One-input engine driving an inverter.
    if_b.expected = 2'b01;
    if_b.start = 1'b1;
    step();
    if_b.start = 1'b0;
    lat = 0;
    while (!if_b.done && lat < 20) begin
      step();
      lat++;
    end
    check("inv_latency", 32'(lat), 32'd4);
    check("inv_table", 32'(if_b.table_out), 32'b01);
    check("inv_pass",  32'(if_b.pass), 32'd1);
    check("inv_mis",   32'(if_b.mismatch_cnt), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
